id1000500a_conv_core: RTL and testbench

Sequential 1-D discrete convolution engine: on `start` it reads vector X (length sizeX) and kernel Y (length sizeY) from two external read-only RAMs and writes Z[k] = Σ X[i]·Y[k−i] for k = 0…sizeX+sizeY−2 into a third RAM. It is the datapath/control core of the convolution coprocessor. It sits between three `simple_dual_port_ram_single_clk_sv` instances, which have a registered read with 1-cycle latency, and the host configuration register.

---
 rtl/id1000500a_conv_core.sv | 180 ++++++++++++++++++
 tb/tb_id1000500a_conv_core.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/id1000500a_conv_core.sv
// id1000500a_conv_core: sequential 1-D convolution engine.
// Reads X and Y from read-only RAMs with one-cycle registered read latency
// and writes Z[k] = sum X[i]*Y[k-i] one word per output index.
//
// state    | meaning
// ---------+---------------------------------------------------------
// S_IDLE   | waiting for start; latches sizes
// S_BOUNDS | clear accumulator, compute i range for current k
// S_ADDR   | X/Y read addresses presented to the RAMs
// S_WAIT   | RAM read latency cycle
// S_MAC    | accumulate dataX*dataY, step i or finish this k
// S_WRITE  | writeZ pulse with acc at address k
// S_DONE   | done_out pulse, back to idle
module id1000500a_conv_core #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    start,
    input  logic [DATA_WIDTH-1:0]   config_in,
    input  logic [DATA_WIDTH-1:0]   dataX,
    output logic [ADDR_WIDTH-1:0]   memX_addr,
    input  logic [DATA_WIDTH-1:0]   dataY,
    output logic [ADDR_WIDTH-1:0]   memY_addr,
    output logic [2*DATA_WIDTH-1:0] dataZ,
    output logic                    writeZ,
    output logic [ADDR_WIDTH:0]     memZ_addr,
    output logic                    busy_out,
    output logic                    done_out
);

    localparam int DW = DATA_WIDTH;
    localparam int AW = ADDR_WIDTH;
    localparam logic [AW-1:0] C_ONE   = 1;
    localparam logic [AW:0]   C_ONE_W = 1;
    localparam logic [AW:0]   C_TWO_W = 2;

    typedef enum logic [2:0] {
        S_IDLE, S_BOUNDS, S_ADDR, S_WAIT, S_MAC, S_WRITE, S_DONE
    } state_t;

    state_t r_state, w_next;

    logic [AW-1:0]   r_size_x, r_size_y;
    logic [AW:0]     r_k;
    logic [AW-1:0]   r_i, r_i_hi;
    logic [2*DW-1:0] r_acc;

    logic [AW-1:0]   r_mem_x_addr, r_mem_y_addr;
    logic [2*DW-1:0] r_data_z;
    logic            r_write_z;
    logic [AW:0]     r_mem_z_addr;
    logic            r_busy, r_done;

    logic [AW-1:0]   w_cfg_x, w_cfg_y;
    logic [AW:0]     w_k_last, w_y_m1, w_lo_full, w_j_full;
    logic [AW-1:0]   w_i_lo, w_i_hi, w_i_addr, w_j;
    logic [2*DW-1:0] w_x_ext, w_y_ext, w_prod, w_acc_sum;
    logic            w_last_i, w_last_k;
    logic            w_busy_nxt, w_write_nxt, w_done_nxt;
    logic            w_unused;

    assign w_cfg_x   = config_in[AW-1:0];
    assign w_cfg_y   = config_in[2*AW-1:AW];

    // Index arithmetic is done one bit wider so k-sizeY+1 and k-i never wrap.
    assign w_k_last  = {1'b0, r_size_x} + {1'b0, r_size_y} - C_TWO_W;
    assign w_y_m1    = {1'b0, r_size_y} - C_ONE_W;
    assign w_lo_full = r_k - w_y_m1;
    assign w_i_lo    = (r_k >= w_y_m1) ? w_lo_full[AW-1:0] : '0;
    assign w_i_hi    = (r_k < {1'b0, r_size_x}) ? r_k[AW-1:0] : (r_size_x - C_ONE);
    assign w_i_addr  = (r_state == S_BOUNDS) ? w_i_lo : (r_i + C_ONE);
    assign w_j_full  = r_k - {1'b0, w_i_addr};
    assign w_j       = w_j_full[AW-1:0];
    assign w_last_i  = (r_i == r_i_hi);
    assign w_last_k  = (r_k == w_k_last);

    // Sign-extended operands; the low 2*DW bits of the product are the exact signed product.
    assign w_x_ext   = {{DW{dataX[DW-1]}}, dataX};
    assign w_y_ext   = {{DW{dataY[DW-1]}}, dataY};
    assign w_prod    = w_x_ext * w_y_ext;
    assign w_acc_sum = r_acc + w_prod;

    assign w_unused  = ^{config_in[DW-1:2*AW], w_lo_full[AW], w_j_full[AW]};

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next = ((w_cfg_x == '0) || (w_cfg_y == '0)) ? S_DONE : S_BOUNDS;
            S_BOUNDS: w_next = S_ADDR;
            S_ADDR:   w_next = S_WAIT;
            S_WAIT:   w_next = S_MAC;
            S_MAC:    w_next = w_last_i ? S_WRITE : S_ADDR;
            S_WRITE:  w_next = w_last_k ? S_DONE : S_BOUNDS;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Output decode from the next state so registered outputs line up with the state.
    always_comb begin
        w_busy_nxt  = (w_next == S_BOUNDS) || (w_next == S_ADDR) || (w_next == S_WAIT) ||
                      (w_next == S_MAC) || (w_next == S_WRITE);
        w_write_nxt = (w_next == S_WRITE);
        w_done_nxt  = (w_next == S_DONE);
    end

    // Counters, latched sizes and accumulator.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_size_x <= '0;
            r_size_y <= '0;
            r_k      <= '0;
            r_i      <= '0;
            r_i_hi   <= '0;
            r_acc    <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (start) begin
                    r_size_x <= w_cfg_x;
                    r_size_y <= w_cfg_y;
                    r_k      <= '0;
                end
                S_BOUNDS: begin
                    r_acc  <= '0;
                    r_i    <= w_i_lo;
                    r_i_hi <= w_i_hi;
                end
                S_MAC: begin
                    r_acc <= w_acc_sum;
                    if (!w_last_i) r_i <= r_i + C_ONE;
                end
                S_WRITE: if (!w_last_k) r_k <= r_k + C_ONE_W;
                default: ;
            endcase
        end
    end

    // Registered outputs; addresses and result hold between updates.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_mem_x_addr <= '0;
            r_mem_y_addr <= '0;
            r_data_z     <= '0;
            r_write_z    <= 1'b0;
            r_mem_z_addr <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_busy    <= w_busy_nxt;
            r_write_z <= w_write_nxt;
            r_done    <= w_done_nxt;
            if (w_next == S_ADDR) begin
                r_mem_x_addr <= w_i_addr;
                r_mem_y_addr <= w_j;
            end
            if (w_write_nxt) begin
                r_data_z     <= w_acc_sum;
                r_mem_z_addr <= r_k;
            end
        end
    end

    assign memX_addr = r_mem_x_addr;
    assign memY_addr = r_mem_y_addr;
    assign dataZ     = r_data_z;
    assign writeZ    = r_write_z;
    assign memZ_addr = r_mem_z_addr;
    assign busy_out  = r_busy;
    assign done_out  = r_done;

endmodule

// File: tb/tb_id1000500a_conv_core.sv
// Bench for id1000500a_conv_core: RAM models, write/busy/done monitor and
// a direct-sum convolution reference.
module tb_id1000500a_conv_core;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] config_in = '0;
    logic [DW-1:0] dataX = '0;
    logic [DW-1:0] dataY = '0;
    logic [AW-1:0] memX_addr, memY_addr;
    logic [2*DW-1:0] dataZ;
    logic          writeZ;
    logic [AW:0]   memZ_addr;
    logic          busy_out, done_out;

    id1000500a_conv_core #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rstn(rstn), .start(start), .config_in(config_in),
        .dataX(dataX), .memX_addr(memX_addr), .dataY(dataY), .memY_addr(memY_addr),
        .dataZ(dataZ), .writeZ(writeZ), .memZ_addr(memZ_addr),
        .busy_out(busy_out), .done_out(done_out)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem_x [32];
    logic [DW-1:0] mem_y [32];

    // Registered-read RAM models.
    always @(posedge clk) begin
        dataX <= mem_x[memX_addr];
        dataY <= mem_y[memY_addr];
    end

    int checks = 0;
    int errors = 0;

    bit  mon_en = 1'b0;
    int  cyc, busy_cnt, done_cnt, done_cyc, write_cnt, first_wr, order_err;
    logic [63:0] z_got [64];
    longint exp_z [64];
    int spec_z [14] = '{1, 4, 10, 20, 35, 50, 65, 80, 95, 110, 114, 106, 85, 50};

    // Observe outputs mid-cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            cyc++;
            if (busy_out) busy_cnt++;
            if (done_out) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (writeZ) begin
                if (memZ_addr != 6'(write_cnt)) order_err++;
                z_got[memZ_addr] = dataZ;
                if (write_cnt == 0) first_wr = cyc;
                write_cnt++;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        cyc = 0; busy_cnt = 0; done_cnt = 0; done_cyc = 0;
        write_cnt = 0; first_wr = 0; order_err = 0;
        for (int k = 0; k < 64; k++) z_got[k] = 'x;
    endtask

    task automatic load_ramp();
        for (int a = 0; a < 32; a++) begin
            mem_x[a] = (a < 10) ? DW'(a + 1) : '0;
            mem_y[a] = (a < 5)  ? DW'(a + 1) : '0;
        end
    endtask

    task automatic load_random();
        for (int a = 0; a < 32; a++) begin
            mem_x[a] = $urandom;
            mem_y[a] = $urandom;
        end
    endtask

    function automatic int n_terms(input int k, input int sx, input int sy);
        int lo, hi;
        lo = (k >= sy - 1) ? k - sy + 1 : 0;
        hi = (k < sx - 1) ? k : sx - 1;
        return hi - lo + 1;
    endfunction

    task automatic pulse_start(input int sx, input int sy);
        logic [DW-1:0] cfg;
        logic [31:0]   sxv, syv;
        sxv = sx;
        syv = sy;
        cfg = $urandom;
        cfg[AW-1:0] = sxv[AW-1:0];
        cfg[2*AW-1:AW] = syv[AW-1:0];
        clear_mon();
        @(negedge clk);
        config_in = cfg;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic do_run(input int sx, input int sy, input bit disturb, input bit spec_cmp);
        int t, n_out, exp_busy;
        for (int k = 0; k < 64; k++) exp_z[k] = 0;
        for (int i = 0; i < sx; i++)
            for (int j = 0; j < sy; j++)
                exp_z[i + j] += longint'($signed(mem_x[i])) * longint'($signed(mem_y[j]));
        n_out    = (sx == 0 || sy == 0) ? 0 : sx + sy - 1;
        exp_busy = (n_out == 0) ? 0 : 2 * n_out + 3 * sx * sy;

        pulse_start(sx, sy);
        t = 0;
        while (done_cnt == 0 && t < 8000) begin
            @(posedge clk);
            #1;
            t++;
            if (disturb) begin
                if (t == 10) begin start = 1'b1; config_in = $urandom; end
                if (t == 14) start = 1'b0;
                if (t == 40) config_in = $urandom;
                if (t == 90) begin start = 1'b1; config_in = '0; end
                if (t == 91) start = 1'b0;
            end
        end
        repeat (4) @(posedge clk);
        #1;
        mon_en = 1'b0;

        check("done_seen", 64'(t < 8000), 64'd1);
        check("write_count", 64'(write_cnt), 64'(n_out));
        check("write_order", 64'(order_err), 64'd0);
        check("busy_cycles", 64'(busy_cnt), 64'(exp_busy));
        check("done_pulses", 64'(done_cnt), 64'd1);
        check("done_cycle", 64'(done_cyc), 64'(exp_busy + 1));
        check("idle_busy", 64'(busy_out), 64'd0);
        if (n_out > 0) check("first_write", 64'(first_wr), 64'd5);
        for (int k = 0; k < n_out; k++) check("z_model", z_got[k], 64'(exp_z[k]));
        if (spec_cmp)
            for (int k = 0; k < 14; k++) check("z_spec", z_got[k], 64'(longint'(spec_z[k])));
    endtask

    initial begin
        int c_mac;

        // Reset behaviour.
        for (int a = 0; a < 32; a++) begin mem_x[a] = '0; mem_y[a] = '0; end
        repeat (3) @(negedge clk);
        check("reset_outputs", 64'({memX_addr, memY_addr, writeZ, memZ_addr, busy_out, done_out}), 64'd0);
        check("reset_dataZ", dataZ, 64'd0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        check("post_reset_busy", 64'(busy_out), 64'd0);
        check("post_reset_done", 64'(done_out), 64'd0);

        // Directed 10x5 ramp.
        load_ramp();
        do_run(10, 5, 1'b0, 1'b1);

        // Signed data.
        for (int a = 0; a < 32; a++) begin
            mem_x[a] = (a < 3) ? 32'hFFFF_FFFF : '0;
            mem_y[a] = (a < 2) ? 32'd2 : '0;
        end
        do_run(3, 2, 1'b0, 1'b0);
        check("signed_z0", z_got[0], 64'hFFFF_FFFF_FFFF_FFFE);
        check("signed_z1", z_got[1], 64'hFFFF_FFFF_FFFF_FFFC);
        check("signed_z2", z_got[2], 64'hFFFF_FFFF_FFFF_FFFC);
        check("signed_z3", z_got[3], 64'hFFFF_FFFF_FFFF_FFFE);

        // Zero-length operands.
        do_run(0, 5, 1'b0, 1'b0);
        do_run(7, 0, 1'b0, 1'b0);

        // Start and config disturbances during a run.
        load_ramp();
        do_run(10, 5, 1'b1, 1'b1);

        // Reset during the MAC of k=3, then a clean recompute.
        c_mac = 1;
        for (int k = 0; k < 3; k++) c_mac += 2 + 3 * n_terms(k, 10, 5);
        c_mac += 3;
        pulse_start(10, 5);
        repeat (c_mac - 1) @(posedge clk);
        #1;
        check("busy_before_abort", 64'(busy_out), 64'd1);
        rstn = 1'b0;
        #1;
        check("abort_outputs", 64'({memX_addr, memY_addr, writeZ, memZ_addr, busy_out, done_out}), 64'd0);
        check("abort_dataZ", dataZ, 64'd0);
        check("abort_writes", 64'(write_cnt), 64'd3);
        repeat (2) @(negedge clk);
        mon_en = 1'b0;
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        check("abort_idle_busy", 64'(busy_out), 64'd0);
        do_run(10, 5, 1'b0, 1'b1);

        // Randomised sizes and data, including the extremes.
        load_random();
        do_run(1, 1, 1'b0, 1'b0);
        for (int r = 0; r < 6; r++) begin
            load_random();
            do_run($urandom_range(1, 8), $urandom_range(1, 8), 1'b0, 1'b0);
        end
        load_random();
        do_run(31, 31, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
